iod_delay_tap_ctrl: RTL and testbench

Sequencing controller for one PolarFire IOD dynamic delay line in the DDR3 PHY lane: TX/RX delay line with DELAY_LINE_LOAD/MOVE/DIRECTION/OUT_OF_RANGE.
- Accepts a target tap value and steps the delay line there, one MOVE pulse at a time, with a settle gap after each pulse.
- Tracks the current tap count and reports out-of-range and completion.
- Sits between the training/calibration FSM and the IOD instance, in the FAB_CLK domain.

---
 rtl/iod_delay_tap_ctrl.sv | 170 +++++++++++++++++
 tb/tb_iod_delay_tap_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/iod_delay_tap_ctrl.sv
`default_nettype none
// ==== iod_delay_tap_ctrl : steps one IOD dynamic delay line to a target tap, one MOVE at a time ====
// ==== Revision 1.0                                                                               ====
module iod_delay_tap_ctrl #(
  parameter int TAP_W         = 8,
  parameter int INIT_TAP      = 1,
  parameter int MAX_TAP       = 255,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             FAB_CLK,
  input  logic             ARST_N,
  input  logic             LOAD_REQ,
  input  logic             REQ_VALID,
  input  logic [TAP_W-1:0] REQ_TARGET,
  output logic             REQ_READY,
  output logic             DONE,
  output logic             DONE_ERR,
  output logic [TAP_W-1:0] CUR_TAP,
  output logic             OOR_STICKY,
  output logic             DELAY_LINE_LOAD_0,
  output logic             DELAY_LINE_MOVE_0,
  output logic             DELAY_LINE_DIRECTION_0,
  input  logic             DELAY_LINE_OUT_OF_RANGE_0
);

  localparam int               CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TAP_W-1:0] C_INIT   = TAP_W'(INIT_TAP);
  localparam logic [TAP_W-1:0] C_MAX    = TAP_W'(MAX_TAP);
  localparam logic [CNT_W-1:0] C_SETTLE = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_MOVE   = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [TAP_W-1:0] cur_q, cur_d;
  logic [TAP_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             dir_q, dir_d;
  logic             was_load_q, was_load_d;
  logic             oor_hit_q, oor_hit_d;
  logic             sticky_q, sticky_d;
  logic             ready_q, done_q, done_err_q, load_q, move_q;
  logic [TAP_W-1:0] req_tgt;
  logic             req_clamped;

  always_comb begin
    req_clamped = (REQ_TARGET > C_MAX);
    req_tgt     = req_clamped ? C_MAX : REQ_TARGET;
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    tgt_d      = tgt_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    dir_d      = dir_q;
    was_load_d = was_load_q;
    oor_hit_d  = oor_hit_q;
    sticky_d   = sticky_q;
    case (state_q)
      S_IDLE: begin
        if (LOAD_REQ) begin
          state_d = S_LOAD;
        end else if (REQ_VALID) begin
          tgt_d = req_tgt;
          err_d = req_clamped;
          if (req_tgt == cur_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_MOVE;
            dir_d   = (req_tgt > cur_q);
          end
        end
      end
      S_LOAD: begin
        cur_d      = C_INIT;
        sticky_d   = 1'b0;
        was_load_d = 1'b1;
        oor_hit_d  = 1'b0;
        cnt_d      = C_SETTLE;
        state_d    = S_SETTLE;
      end
      S_MOVE: begin
        cur_d      = dir_q ? cur_q + 1'b1 : cur_q - 1'b1;
        was_load_d = 1'b0;
        oor_hit_d  = 1'b0;
        cnt_d      = C_SETTLE;
        state_d    = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q - 1'b1;
        if (DELAY_LINE_OUT_OF_RANGE_0) begin
          sticky_d  = 1'b1;
          err_d     = 1'b1;
          oor_hit_d = 1'b1;
          // The IOD refused the step: roll the optimistic count back, once per settle window.
          if (!oor_hit_q && !was_load_q) begin
            cur_d = dir_q ? cur_q - 1'b1 : cur_q + 1'b1;
          end
        end
        if (cnt_q == C_ONE) begin
          if (oor_hit_d || was_load_q || (cur_d == tgt_q)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_MOVE;
            dir_d   = (tgt_q > cur_q);
          end
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK) begin
    if (!ARST_N) begin
      state_q    <= S_IDLE;
      cur_q      <= C_INIT;
      tgt_q      <= C_INIT;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      dir_q      <= 1'b0;
      was_load_q <= 1'b0;
      oor_hit_q  <= 1'b0;
      sticky_q   <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      load_q     <= 1'b0;
      move_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      tgt_q      <= tgt_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      dir_q      <= dir_d;
      was_load_q <= was_load_d;
      oor_hit_q  <= oor_hit_d;
      sticky_q   <= sticky_d;
      ready_q    <= (state_d == S_IDLE);
      done_q     <= (state_d == S_DONE);
      done_err_q <= (state_d == S_DONE) && err_d;
      load_q     <= (state_d == S_LOAD);
      move_q     <= (state_d == S_MOVE);
    end
  end

  assign REQ_READY              = ready_q;
  assign DONE                   = done_q;
  assign DONE_ERR               = done_err_q;
  assign CUR_TAP                = cur_q;
  assign OOR_STICKY             = sticky_q;
  assign DELAY_LINE_LOAD_0      = load_q;
  assign DELAY_LINE_MOVE_0      = move_q;
  assign DELAY_LINE_DIRECTION_0 = dir_q;

endmodule
`default_nettype wire

// File: tb/tb_iod_delay_tap_ctrl.sv
`default_nettype none
// ==== tb_iod_delay_tap_ctrl : directed + randomized bench for iod_delay_tap_ctrl ====
// ==== Revision 1.0                                                               ====
module tb_iod_delay_tap_ctrl;
  localparam int TAP_W    = 8;
  localparam int INIT_TAP = 1;
  localparam int MAX_TAP  = 10;
  localparam int SETTLE   = 4;
  localparam int PERIOD   = 1 + SETTLE;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load_req = 1'b0;
  logic             req_valid = 1'b0;
  logic [TAP_W-1:0] req_target = '0;
  logic             oor = 1'b0;
  logic             ready, done, done_err, sticky, dl_load, dl_move, dl_dir;
  logic [TAP_W-1:0] cur_tap;

  int checks = 0;
  int failures = 0;
  int m_cur = INIT_TAP;
  bit m_sticky = 1'b0;

  iod_delay_tap_ctrl #(
    .TAP_W(TAP_W), .INIT_TAP(INIT_TAP), .MAX_TAP(MAX_TAP), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .FAB_CLK(clk),
    .ARST_N(rst_n),
    .LOAD_REQ(load_req),
    .REQ_VALID(req_valid),
    .REQ_TARGET(req_target),
    .REQ_READY(ready),
    .DONE(done),
    .DONE_ERR(done_err),
    .CUR_TAP(cur_tap),
    .OOR_STICKY(sticky),
    .DELAY_LINE_LOAD_0(dl_load),
    .DELAY_LINE_MOVE_0(dl_move),
    .DELAY_LINE_DIRECTION_0(dl_dir),
    .DELAY_LINE_OUT_OF_RANGE_0(oor)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_ready"}, ready, 1);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_done_err"}, done_err, 0);
    chk({pfx, "_sticky"}, sticky, 0);
    chk({pfx, "_load"}, dl_load, 0);
    chk({pfx, "_move"}, dl_move, 0);
    chk({pfx, "_dir"}, dl_dir, 0);
    chk({pfx, "_cur"}, cur_tap, INIT_TAP);
  endtask

  // Called on a falling edge with the controller idle.
  task automatic do_load();
    int loads, load_at, done_at, busy_ready, moves;
    loads = 0; load_at = -1; done_at = -1; busy_ready = 0; moves = 0;
    chk("load_pre_ready", ready, 1);
    load_req = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 40 && done_at < 0; c++) begin
      @(negedge clk);
      if (c == 1) load_req = 1'b0;
      if (dl_load) begin loads++; load_at = c; end
      if (dl_move) moves++;
      if (done) begin
        done_at = c;
        chk("load_done_err", done_err, 0);
        chk("load_cur", cur_tap, INIT_TAP);
        chk("load_sticky", sticky, 0);
      end else if (ready) busy_ready++;
    end
    chk("load_pulses", loads, 1);
    chk("load_pulse_at", load_at, 1);
    chk("load_moves", moves, 0);
    chk("load_done_at", done_at, 2 + SETTLE);
    chk("load_busy_ready", busy_ready, 0);
    @(negedge clk);
    chk("load_done_1cyc", done, 0);
    chk("load_ready_back", ready, 1);
    m_cur = INIT_TAP;
    m_sticky = 1'b0;
  endtask

  // oor_pulse: IOD refuses the step issued by that pulse (0 = never).
  // abort_cycle: assert reset at that cycle after accept (0 = never).
  task automatic do_move(input int target, input int oor_pulse, input int abort_cycle);
    int t, n, exp_pulses, exp_final, pulses, done_at, busy_ready, oor_at, wait_c;
    bit exp_err, exp_dir, oor_used;
    t = (target > MAX_TAP) ? MAX_TAP : target;
    exp_err = (target > MAX_TAP);
    n = (t > m_cur) ? t - m_cur : m_cur - t;
    exp_dir = (t > m_cur);
    exp_pulses = n;
    exp_final = t;
    oor_used = 1'b0;
    if (oor_pulse > 0 && oor_pulse <= n) begin
      oor_used = 1'b1;
      exp_pulses = oor_pulse;
      exp_final = exp_dir ? m_cur + oor_pulse - 1 : m_cur - (oor_pulse - 1);
      exp_err = 1'b1;
    end
    pulses = 0; done_at = -1; busy_ready = 0; oor_at = -1; wait_c = 0;
    req_valid = 1'b1;
    req_target = TAP_W'(target);
    while (ready !== 1'b1 && wait_c < 20) begin
      @(negedge clk);
      wait_c++;
    end
    chk("move_accept_ready", ready, 1);
    @(posedge clk);
    for (int c = 1; c <= 80 && done_at < 0; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      oor = (c == oor_at);
      if (dl_move) begin
        chk("move_pulse_at", c, 1 + PERIOD * pulses);
        chk("move_dir", dl_dir, exp_dir);
        pulses++;
        if (pulses == oor_pulse) oor_at = c + $urandom_range(1, SETTLE);
      end
      if (done) begin
        done_at = c;
        chk("move_done_err", done_err, exp_err);
        chk("move_cur", cur_tap, exp_final);
        chk("move_sticky", sticky, m_sticky | oor_used);
      end else if (ready) busy_ready++;
      if (c == abort_cycle) begin
        oor = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("abort");
        rst_n = 1'b1;
        m_cur = INIT_TAP;
        m_sticky = 1'b0;
        return;
      end
    end
    oor = 1'b0;
    chk("move_pulses", pulses, exp_pulses);
    chk("move_done_at", done_at, 1 + PERIOD * exp_pulses);
    chk("move_busy_ready", busy_ready, 0);
    @(negedge clk);
    chk("move_done_1cyc", done, 0);
    chk("move_ready_back", ready, 1);
    m_cur = exp_final;
    if (oor_used) m_sticky = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_load();
    do_move(4, 0, 0);
    do_move(0, 0, 0);
    do_move(3, 2, 0);
    do_move(5, 0, 0);
    do_load();
    do_move(200, 0, 0);
    do_move(12, 0, 0);
    do_move(10, 0, 0);

    // Load and move requested together: load wins, held request follows.
    req_valid = 1'b1;
    req_target = TAP_W'(3);
    do_load();
    do_move(3, 0, 0);

    do_move(8, 0, 8);
    @(negedge clk);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_load();
      end else begin
        do_move($urandom_range(0, 15),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 0, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
